// File: rtl/pulse_meas_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meas_ctrl_if
// Description : Result handshake bundle for the pulse measurement sequencer.
//               master = producer of the measurement, slave = consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_meas_ctrl_if #(
    parameter int CNT_W = 21
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_width;
    logic [CNT_W-1:0] res_period;
    logic             res_timeout;

    modport master (
        output res_valid,
        output res_width,
        output res_period,
        output res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_width,
        input  res_period,
        input  res_timeout,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/pulse_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meas_ctrl
// Description : Synchronises DATA_IN, detects edges and measures one pulse
//               (high width and rise-to-rise period) per arm request. The
//               result is held on a valid/ready port until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_meas_ctrl #(
    parameter int TIMEOUT     = 1000,
    parameter int CNT_W       = 21,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          CLK_IN,
    input  wire logic          rst_n,
    input  wire logic          DATA_IN,
    input  wire logic          arm,
    pulse_meas_ctrl_if.master  res,
    output logic               busy,
    output logic [2:0]         state_o,
    output logic [7:0]         pulse_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RISE = 3'd1,
        S_HIGH      = 3'd2,
        S_LOW       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ZERO    = '0;
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_width;
    logic [CNT_W-1:0]       r_period;
    logic                   r_tout;
    logic [7:0]             r_count;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_width_nxt;
    logic [CNT_W-1:0]       w_period_nxt;
    logic                   w_tout_nxt;
    logic [7:0]             w_count_nxt;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_at_limit;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_prev;
    assign w_fall     = ~w_s & r_prev;
    assign w_at_limit = (r_cnt == C_TIMEOUT);
    // Saturating increment keeps cnt within TIMEOUT even when an edge
    // arrives exactly on the limit cycle and the FSM moves on.
    assign w_cnt_inc  = w_at_limit ? r_cnt : r_cnt + C_ONE;

    // Input synchroniser and edge-detect history, running in every state.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], DATA_IN};
            r_prev <= w_s;
        end
    end

    // State and measurement registers.
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_width  <= '0;
            r_period <= '0;
            r_tout   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_width  <= w_width_nxt;
            r_period <= w_period_nxt;
            r_tout   <= w_tout_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Next-state and datapath update; an edge takes priority over timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_width_nxt  = r_width;
        w_period_nxt = r_period;
        w_tout_nxt   = r_tout;
        w_count_nxt  = r_count;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt  = S_WAIT_RISE;
                    w_cnt_nxt    = C_ZERO;
                    w_tout_nxt   = 1'b0;
                    w_width_nxt  = C_ZERO;
                    w_period_nxt = C_ZERO;
                end
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = C_ONE;
                end else if (w_at_limit) begin
                    w_state_nxt = S_DONE;
                    w_tout_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                    w_width_nxt = r_cnt;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (w_at_limit) begin
                    w_state_nxt  = S_DONE;
                    w_tout_nxt   = 1'b1;
                    w_width_nxt  = r_cnt;
                    w_period_nxt = C_ZERO;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_state_nxt  = S_DONE;
                    w_period_nxt = r_cnt;
                    w_count_nxt  = r_count + 8'd1;
                end else if (w_at_limit) begin
                    w_state_nxt  = S_DONE;
                    w_tout_nxt   = 1'b1;
                    w_period_nxt = C_ZERO;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
                end
            end
            S_DONE: begin
                if (res.res_ready) begin
                    if (arm) begin
                        w_state_nxt  = S_WAIT_RISE;
                        w_cnt_nxt    = C_ZERO;
                        w_tout_nxt   = 1'b0;
                        w_width_nxt  = C_ZERO;
                        w_period_nxt = C_ZERO;
                    end else begin
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign res.res_valid   = (r_state == S_DONE);
    assign res.res_width   = r_width;
    assign res.res_period  = r_period;
    assign res.res_timeout = r_tout;
    assign busy            = (r_state == S_WAIT_RISE) || (r_state == S_HIGH) ||
                             (r_state == S_LOW);
    assign state_o         = r_state;
    assign pulse_count     = r_count;

endmodule
`default_nettype wire
